// File: rtl/ddr_pkg.sv
// Shared HDR-DDR definitions used by tx, the DDR/CCC controller and the CRC-5 generator.
package ddr_pkg;

  localparam logic [4:0] CRC5_POLY     = 5'b00101;
  localparam logic [4:0] CRC5_INIT     = 5'b11111;
  localparam logic [3:0] DDR_TOKEN_CRC = 4'b1100;

  typedef enum logic [1:0] {
    TX_MODE_IDLE     = 2'b00,
    TX_MODE_SDR      = 2'b01,
    TX_MODE_DDR_CMD  = 2'b10,
    TX_MODE_DDR_DATA = 2'b11
  } tx_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } crc_state_t;

endpackage

// File: rtl/crc5_bit_step.sv
// Single-bit CRC-5 update for x^5+x^2+1: shift left, fold the polynomial in on feedback.
module crc5_bit_step
  import ddr_pkg::*;
(
  input  logic [4:0] i_crc,
  input  logic       i_bit,
  output logic [4:0] o_crc
);

  logic w_fb;

  assign w_fb  = i_crc[4] ^ i_bit;
  assign o_crc = {i_crc[3:0], 1'b0} ^ (w_fb ? CRC5_POLY : 5'b00000);

endmodule

// File: rtl/ddr_crc5_gen.sv
// Bit-serial HDR-DDR CRC-5 over tx data bytes, MSB first, with a one-deep byte holding register.
//   state | meaning
//   IDLE  | no byte shifting; CRC stable (valid once a byte has been seen since clear)
//   SHIFT | one byte bit per clock into the CRC, counter 0..DATA_WIDTH-1
module ddr_crc5_gen
  import ddr_pkg::*;
#(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   CRC_WIDTH  = 5,
  parameter logic [CRC_WIDTH-1:0] CRC_INIT   = CRC5_INIT
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_ddrccc_crc_clr,
  input  logic                  i_tx_crc_en,
  input  logic [DATA_WIDTH-1:0] i_tx_parallel_data,
  input  logic                  i_tx_byte_strobe,
  output logic [CRC_WIDTH-1:0]  o_crc_value,
  output logic                  o_crc_valid,
  output logic                  o_crc_busy,
  output logic                  o_crc_overflow
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  crc_state_t            r_state;
  logic [CRC_WIDTH-1:0]  r_crc;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf;
  logic                  r_seen;

  crc_state_t            w_state_nxt;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_load_data;
  logic                  w_load_hold;
  logic                  w_hold_cap;
  logic                  w_hold_full_nxt;
  logic                  w_ovf_set;
  logic [CRC_WIDTH-1:0]  w_crc_step;

  crc5_bit_step u_step (
    .i_crc (r_crc),
    .i_bit (r_shift[DATA_WIDTH-1]),
    .o_crc (w_crc_step)
  );

  assign w_accept = i_tx_byte_strobe & i_tx_crc_en;
  assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_load_data = 1'b0;
    w_load_hold = 1'b0;
    w_hold_cap  = 1'b0;
    w_ovf_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_state_nxt = SHIFT;
          w_load_hold = 1'b1;
          w_hold_cap  = w_accept;
        end else if (w_accept) begin
          w_state_nxt = SHIFT;
          w_load_data = 1'b1;
        end
      end
      SHIFT: begin
        if (w_last) begin
          // The held byte leaves this cycle, so a new strobe can take its slot.
          if (r_hold_full) w_load_hold = 1'b1;
          else             w_state_nxt = IDLE;
          w_hold_cap = w_accept;
        end else if (w_accept) begin
          if (r_hold_full) w_ovf_set  = 1'b1;
          else             w_hold_cap = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_ddrccc_crc_clr) begin
      w_state_nxt = w_accept ? SHIFT : IDLE;
      w_load_data = w_accept;
      w_load_hold = 1'b0;
      w_hold_cap  = 1'b0;
      w_ovf_set   = 1'b0;
    end
    w_hold_full_nxt = w_hold_cap ? 1'b1 : (w_load_hold ? 1'b0 : r_hold_full);
    if (i_ddrccc_crc_clr) w_hold_full_nxt = 1'b0;
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state     <= IDLE;
      r_crc       <= CRC_INIT;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_seen      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_full <= w_hold_full_nxt;
      if (w_hold_cap) r_hold <= i_tx_parallel_data;

      if (i_ddrccc_crc_clr)     r_crc <= CRC_INIT;
      else if (r_state == SHIFT) r_crc <= w_crc_step;

      if (i_ddrccc_crc_clr) r_ovf <= 1'b0;
      else if (w_ovf_set)   r_ovf <= 1'b1;

      if (w_load_data || w_load_hold) begin
        r_shift <= w_load_hold ? r_hold : i_tx_parallel_data;
        r_cnt   <= '0;
        r_seen  <= 1'b1;
      end else begin
        if (r_state == SHIFT) begin
          r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        if (i_ddrccc_crc_clr) r_seen <= 1'b0;
      end
    end
  end

  assign o_crc_value    = r_crc;
  assign o_crc_valid    = (r_state == IDLE) && !r_hold_full && r_seen;
  assign o_crc_busy     = (r_state == SHIFT) || r_hold_full;
  assign o_crc_overflow = r_ovf;

endmodule

// File: doc/ddr_crc5_gen.md
Name: ddr_crc5_gen

Overview:
- Computes the HDR-DDR CRC-5 over every data byte the serializer (tx) sends.
- Bytes are processed bit-serially, MSB first; the running CRC is returned to tx on its `i_crc_crc_value` input.
- Sits between tx and the DDR/CCC controller, which clears it at the start of each data block.
- Has a one-deep holding register so a byte strobe is never lost while the previous byte is still shifting.

Parameters:
- DATA_WIDTH, 8, bits per byte processed per strobe.
- CRC_WIDTH, 5, CRC register width; only 5 is supported.
- CRC_INIT, 5'b11111, value loaded by reset and by clear.

Ports:
- i_sys_clk  in  1  system clock.
- i_sys_rst  in  1  reset; synchronous, active-high.
- i_ddrccc_crc_clr  in  1  one-cycle pulse; starts a new block and reloads CRC_INIT.
- i_tx_crc_en  in  1  level from tx; strobes are ignored while it is low.
- i_tx_parallel_data  in  DATA_WIDTH  byte from tx (`o_crc_parallel_data`).
- i_tx_byte_strobe  in  1  one-cycle pulse; the byte on `i_tx_parallel_data` is complete and stable.
- o_crc_value  out  CRC_WIDTH  CRC over all bytes since the last clear; drives tx `i_crc_crc_value`.
- o_crc_valid  out  1  high when idle, nothing pending, and at least one byte has been processed since clear.
- o_crc_busy  out  1  high while in SHIFT or while the holding register is full.
- o_crc_overflow  out  1  sticky error flag.

Behaviour:
- Reset (sync, high):
  - crc_reg = CRC_INIT; `o_crc_value` = 5'b11111.
  - `o_crc_valid`, `o_crc_busy`, `o_crc_overflow` = 0.
  - State = IDLE; holding register empty; bit counter = 0.
- Accept condition: `i_tx_byte_strobe` && `i_tx_crc_en`. A strobe with en low is ignored and has no side effects.
- Polynomial x^5+x^2+1, one data bit d per clock:
  - fb = crc[4]^d
  - crc_next = {crc[3], crc[2], crc[1]^fb, crc[0], fb}
- FSM states: IDLE, SHIFT.
  - IDLE: on accept, load shift register with the byte, clear the bit counter, go to SHIFT. `o_crc_valid` drops in the same cycle.
  - SHIFT: one bit per clock, MSB first, for 8 clocks (counter 0..7). At counter 7:
    - holding register full: load the held byte, empty the holding register, stay in SHIFT, counter = 0.
    - holding register empty: go to IDLE.
- Latency: `o_crc_value` reflects a byte 8 clocks after its accepting edge. `o_crc_valid` rises 9 clocks after the strobe (first IDLE cycle).
- `o_crc_value` is driven from crc_reg at all times. It is only meaningful when `o_crc_valid` = 1.
- Accept while in SHIFT:
  - holding register empty: byte goes to the holding register.
  - holding register full: byte is dropped and `o_crc_overflow` is set.
  - Accept in the last SHIFT cycle with the holding register empty: byte goes to the holding register, then chains into SHIFT in the next cycle.
- `i_ddrccc_crc_clr` has highest priority:
  - crc_reg = CRC_INIT, holding register emptied, state = IDLE, `o_crc_valid` = 0, `o_crc_overflow` cleared.
  - Clear during SHIFT discards the byte in progress.
- Clear and accept in the same cycle: clear is applied first, then the byte is loaded as the first byte of the new block (state = SHIFT from CRC_INIT).
- Counter has no wrap-around hazard: it resets on every load; a value of 8 is never reached.
- `o_crc_valid` stays high until the next accept or clear. No ack from tx is required.

Decomposition:
- Shared package ddr_pkg holds:
  - CRC5_POLY = 5'b00101
  - CRC5_INIT = 5'b11111
  - DDR_TOKEN_CRC = 4'b1100
  - the tx mode encoding (shared with tx and the DDR controller)
  - state enum crc_state_t {IDLE, SHIFT}
- One natural sub-module: crc5_bit_step, the combinational single-bit update, reused by the bench reference model.
- The FSM, holding register and counter stay in the top module.

Test Plan:
- Reset, then clear, then byte 0x00 with en=1 → after 8 clocks `o_crc_value` = 5'b01111; `o_crc_valid` = 1 on the 9th clock.
- Clear, then byte 0xFF → `o_crc_value` = 5'b11011.
- Clear, then bytes 0x00 and 0xFF strobed on consecutive clocks → second byte goes to the holding register; no overflow; `o_crc_busy` = 1 for 16 clocks; final value matches the reference model chained from 5'b01111.
- Three strobes within one SHIFT window → third byte dropped; `o_crc_overflow` = 1; a following clear drops it to 0 and `o_crc_value` = 5'b11111.
- Clear asserted at bit 4 of byte 0xA5 → `o_crc_value` = 5'b11111, state IDLE, `o_crc_valid` = 0. Clear+strobe of 0x00 in the same cycle → result 5'b01111.
- Strobe with `i_tx_crc_en` = 0 → no state change; `o_crc_busy` stays 0; sync reset mid-SHIFT → all outputs at reset values on the next clock.
